// File: rtl/vector_pkg.sv
// Shared vector/fixed-point types for the rendering pipeline, plus the
// scan-state encoding used by the frame controller.
//   fp           : 32-bit signed fixed-point container
//   FRAC_BITS    : fractional bits in fp
//   scan_state_t : IDLE / SCAN / DRAIN
package vector_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fp;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/common_defs.svh
// Shared screen geometry for the rendering pipeline.
//   SCREEN_WIDTH  : pixels per line
//   SCREEN_HEIGHT : lines per frame
`ifndef COMMON_DEFS_SVH
`define COMMON_DEFS_SVH

`define SCREEN_WIDTH  640
`define SCREEN_HEIGHT 480

`endif

// File: rtl/credit_counter.sv
// Outstanding-item counter for credit-based flow control.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   inc            : one item issued this cycle
//   dec            : one item completed this cycle
//   count          : registered outstanding count (0..MAX)
//   full           : count has reached MAX
//   underflow_err  : sticky, dec arrived while nothing was outstanding
module credit_counter #(
  parameter int MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] count,
  output logic       full,
  output logic       underflow_err
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] count_r;
  logic       err_r;

  // Count issues minus completions; a stray completion at zero flags an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      if (inc && !dec) begin
        count_r <= count_r + 8'd1;
      end else if (dec && !inc) begin
        if (count_r == 8'd0) begin
          err_r <= 1'b1;
        end else begin
          count_r <= count_r - 8'd1;
        end
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign count         = count_r;
  assign full          = (count_r >= MAX_C);
  assign underflow_err = err_r;

endmodule

// File: rtl/pixel_scanner.sv
// Raster-order pixel coordinate generator feeding ray_generator.
// Flow control is credit based: a pixel is issued only while fewer than
// MAX_INFLIGHT pixels are outstanding; each pixel_done returns one credit.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start         : pulse, begins a frame when idle
//   continuous    : sampled with start, 1 = back-to-back frames
//   stop          : pulse, finish current frame then go idle
//   pixel_done    : one pulse per pixel completed downstream
//   screen_x/y    : integer pixel coordinates in an fp container
//   coords_valid  : one-cycle strobe per issued pixel
//   sof / eol     : first pixel of frame / last pixel of line
//   busy          : controller not idle
//   frame_done    : one-cycle pulse when a frame has fully drained
//   frame_count   : completed frames, wrapping
//   credit_err    : sticky, pixel_done with nothing outstanding
`include "common_defs.svh"

module pixel_scanner
  import vector_pkg::*;
#(
  parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
  parameter int MAX_INFLIGHT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic        pixel_done,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        coords_valid,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        credit_err
);

  localparam fp X_LAST = fp'(SCREEN_WIDTH - 1);
  localparam fp Y_LAST = fp'(SCREEN_HEIGHT - 1);

  scan_state_t state_r, state_nxt_s;

  fp           x_r, y_r;
  logic        cont_r;
  logic        stop_pending_r;

  fp           screen_x_r, screen_y_r;
  logic        coords_valid_r, sof_r, eol_r, busy_r, frame_done_r;
  logic [15:0] frame_count_r;

  logic        issue_s, last_pix_s, stop_eff_s;
  logic        start_frame_s, restart_s, frame_end_s;
  logic [7:0]  inflight_s;
  logic        full_s, cerr_s;

  credit_counter #(
    .MAX (MAX_INFLIGHT)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc           (issue_s),
    .dec           (pixel_done),
    .count         (inflight_s),
    .full          (full_s),
    .underflow_err (cerr_s)
  );

  assign issue_s    = (state_r == SCAN) && !full_s;
  assign last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);
  // A stop arriving in the very cycle the frame drains still prevents a restart.
  assign stop_eff_s = stop_pending_r | stop;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and frame control strobes.
  always_comb begin
    state_nxt_s   = state_r;
    start_frame_s = 1'b0;
    restart_s     = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s   = SCAN;
          start_frame_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (issue_s && last_pix_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DRAIN: begin
        if (inflight_s == 8'd0) begin
          frame_end_s = 1'b1;
          if (cont_r && !stop_eff_s) begin
            state_nxt_s = SCAN;
            restart_s   = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Mode latches: continuous flag captured at start, stop remembered until frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont_r         <= 1'b0;
      stop_pending_r <= 1'b0;
    end else if (start_frame_s) begin
      cont_r         <= continuous;
      stop_pending_r <= 1'b0;
    end else if ((state_r != IDLE) && stop) begin
      stop_pending_r <= 1'b1;
    end else begin
      stop_pending_r <= stop_pending_r;
    end
  end

  // Raster position: advances once per issued pixel, wrapping at line/frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r <= '0;
      y_r <= '0;
    end else if (start_frame_s || restart_s) begin
      x_r <= '0;
      y_r <= '0;
    end else if (issue_s) begin
      if (x_r == X_LAST) begin
        x_r <= '0;
        y_r <= (y_r == Y_LAST) ? '0 : (y_r + 32'sd1);
      end else begin
        x_r <= x_r + 32'sd1;
      end
    end else begin
      x_r <= x_r;
    end
  end

  // Registered pixel output; coordinates hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      screen_x_r     <= '0;
      screen_y_r     <= '0;
      coords_valid_r <= 1'b0;
      sof_r          <= 1'b0;
      eol_r          <= 1'b0;
    end else begin
      coords_valid_r <= issue_s;
      sof_r          <= issue_s && (x_r == '0) && (y_r == '0);
      eol_r          <= issue_s && (x_r == X_LAST);
      if (issue_s) begin
        screen_x_r <= x_r;
        screen_y_r <= y_r;
      end else begin
        screen_x_r <= screen_x_r;
        screen_y_r <= screen_y_r;
      end
    end
  end

  // Registered status: busy tracks the next state so it equals state != IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      busy_r       <= (state_nxt_s != IDLE);
      frame_done_r <= frame_end_s;
      if (frame_end_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign screen_x     = screen_x_r;
  assign screen_y     = screen_y_r;
  assign coords_valid = coords_valid_r;
  assign sof          = sof_r;
  assign eol          = eol_r;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign frame_count  = frame_count_r;
  assign credit_err   = cerr_s;

endmodule

// File: tb/tb_pixel_scanner.sv
// Self-checking bench for pixel_scanner (4x3 screen, 2 credits).
// A pixel-index reference model predicts every output each cycle; downstream
// completions are echoed back after a configurable delay.
module tb_pixel_scanner;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int MAX  = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        stop = 1'b0;
  logic        pixel_done = 1'b0;
  logic [31:0] screen_x, screen_y;
  logic        coords_valid, sof, eol, busy, frame_done, credit_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  pixel_scanner #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .MAX_INFLIGHT  (MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .stop         (stop),
    .pixel_done   (pixel_done),
    .screen_x     (screen_x),
    .screen_y     (screen_y),
    .coords_valid (coords_valid),
    .sof          (sof),
    .eol          (eol),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .credit_err   (credit_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: 0 idle, 1 scanning, 2 waiting for drain
  int          m_mode, m_idx, m_out;
  bit          m_cont, m_stopp, m_cerr;
  logic [15:0] m_fcount;
  logic [31:0] e_x, e_y;
  bit          e_valid, e_sof, e_eol, e_fdone;

  int due_q[$];
  int echo_delay = 3;
  bit echo_en    = 1'b1;
  bit manual_pd  = 1'b0;
  int dut_valids = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_out = 0;
    m_cont = 1'b0; m_stopp = 1'b0; m_cerr = 1'b0;
    m_fcount = 16'd0;
    e_x = 32'd0; e_y = 32'd0;
    e_valid = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_fdone = 1'b0;
    due_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(coords_valid), 32'd0);
    chk({tag, "_x"},     screen_x,          32'd0);
    chk({tag, "_y"},     screen_y,          32'd0);
    chk({tag, "_sof"},   32'(sof),          32'd0);
    chk({tag, "_eol"},   32'(eol),          32'd0);
    chk({tag, "_busy"},  32'(busy),         32'd0);
    chk({tag, "_fdone"}, 32'(frame_done),   32'd0);
    chk({tag, "_fcnt"},  32'(frame_count),  32'd0);
    chk({tag, "_cerr"},  32'(credit_err),   32'd0);
  endtask

  // One clock: choose pixel_done, predict, clock, compare.
  task automatic step();
    bit pd, issue, found, stop_eff;
    int out_before;
    pd = 1'b0;
    found = 1'b0;
    if (manual_pd) begin
      pd = 1'b1;
      if (due_q.size() > 0) due_q.delete(0);
    end else if (echo_en) begin
      for (int i = 0; i < due_q.size(); i++) begin
        if (!found && due_q[i] <= cyc + 1) begin
          found = 1'b1;
          due_q.delete(i);
        end
      end
      pd = found;
    end
    pixel_done = pd;

    out_before = m_out;
    issue   = (m_mode == 1) && (m_out < MAX);
    e_valid = issue;
    e_sof   = 1'b0;
    e_eol   = 1'b0;
    e_fdone = 1'b0;
    if (issue) begin
      e_x   = 32'(m_idx % W);
      e_y   = 32'(m_idx / W);
      e_sof = (m_idx == 0);
      e_eol = ((m_idx % W) == W - 1);
      m_idx++;
      due_q.push_back(cyc + 1 + echo_delay);
    end
    case (m_mode)
      0: if (start) begin
        m_mode = 1; m_cont = continuous; m_stopp = 1'b0; m_idx = 0;
      end
      1: begin
        if (stop) m_stopp = 1'b1;
        if (m_idx == NPIX) m_mode = 2;
      end
      default: begin
        stop_eff = m_stopp || stop;
        if (stop) m_stopp = 1'b1;
        if (out_before == 0) begin
          e_fdone = 1'b1;
          m_fcount++;
          if (m_cont && !stop_eff) begin
            m_mode = 1; m_idx = 0;
          end else begin
            m_mode = 0;
          end
        end
      end
    endcase
    if (issue && !pd) m_out++;
    else if (pd && !issue) begin
      if (m_out == 0) m_cerr = 1'b1;
      else m_out--;
    end

    @(posedge clk);
    cyc++;
    #1;
    chk("valid", 32'(coords_valid), 32'(e_valid));
    chk("x",     screen_x,          e_x);
    chk("y",     screen_y,          e_y);
    chk("sof",   32'(sof),          32'(e_sof));
    chk("eol",   32'(eol),          32'(e_eol));
    chk("busy",  32'(busy),         32'(m_mode != 0));
    chk("fdone", 32'(frame_done),   32'(e_fdone));
    chk("fcnt",  32'(frame_count),  32'(m_fcount));
    chk("cerr",  32'(credit_err),   32'(m_cerr));
    if (coords_valid) dut_valids++;
    start = 1'b0;
    stop = 1'b0;
    manual_pd = 1'b0;
    pixel_done = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((m_mode != 0 || due_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] f0;
    int n;
    model_reset();

    // power-on reset
    #2 rst = 1'b0;
    #1 check_all_zero("rst");
    @(posedge clk);
    #1 rst = 1'b1;

    // single frame, completions echoed after 3 cycles
    echo_en = 1'b1; echo_delay = 3; dut_valids = 0;
    start = 1'b1; continuous = 1'b0;
    step();
    run_until_idle(100, "t1");
    chk("t1_pixels", 32'(dut_valids), 32'd12);
    chk("t1_fcnt",   32'(frame_count), 32'd1);

    // credit stall with no completions
    echo_en = 1'b0; dut_valids = 0;
    start = 1'b1;
    repeat (10) step();
    chk("t2_stall", 32'(dut_valids), 32'd2);
    manual_pd = 1'b1;
    step();
    dut_valids = 0;
    repeat (4) step();
    chk("t2_one_more", 32'(dut_valids), 32'd1);
    echo_en = 1'b1;
    run_until_idle(200, "t2");

    // completion in the same cycle as issue keeps 1 pixel/clk
    echo_delay = 1;
    start = 1'b1;
    step();
    dut_valids = 0;
    repeat (12) step();
    chk("t3_rate", 32'(dut_valids), 32'd12);
    run_until_idle(50, "t3");

    // continuous, stop in the middle of the second frame
    echo_delay = 3;
    f0 = frame_count;
    start = 1'b1; continuous = 1'b1;
    step();
    n = 0;
    while (!(m_fcount == f0 + 16'd1 && m_mode == 1 && m_idx >= 6) && n < 200) begin
      step();
      n++;
    end
    stop = 1'b1;
    step();
    run_until_idle(200, "t4");
    chk("t4_fcnt", 32'(frame_count), 32'(f0 + 16'd2));
    dut_valids = 0;
    repeat (10) step();
    chk("t4_quiet", 32'(dut_valids), 32'd0);

    // asynchronous reset in mid-frame, around pixel (2,1)
    start = 1'b1; continuous = 1'b0;
    step();
    n = 0;
    while (m_idx < 7 && n < 100) begin
      step();
      n++;
    end
    #2 rst = 1'b0;
    #1 check_all_zero("t5_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b1;
    step();
    step();
    chk("t5_first_sof", 32'(sof), 32'd1);
    run_until_idle(100, "t5");

    // stray completion with nothing outstanding
    manual_pd = 1'b1;
    step();
    chk("t6_cerr", 32'(credit_err), 32'd1);
    start = 1'b1;
    step();
    run_until_idle(100, "t6");

    // random traffic
    repeat (800) begin
      echo_delay = int'($urandom_range(1, 5));
      start      = ($urandom_range(0, 9) == 0);
      continuous = $urandom_range(0, 1) == 1;
      stop       = ($urandom_range(0, 19) == 0);
      step();
    end
    n = 0;
    while (m_mode != 0 && n < 200) begin
      stop = 1'b1;
      step();
      n++;
    end
    run_until_idle(100, "t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_scanner.md
Name: pixel_scanner

Overview:
- Upstream stage of ray_generator: generates the raster-order pixel coordinate stream (screen_x, screen_y, coords_valid) that ray_generator consumes.
- ray_generator has no ready input, so flow control is credit-based. At most MAX_INFLIGHT pixels may be outstanding between issue and completion at the ray-marcher output.
- Supports single-frame and continuous rendering, with frame markers and a frame counter.

Parameters:
- SCREEN_WIDTH, `SCREEN_WIDTH (640): pixels per line.
- SCREEN_HEIGHT, `SCREEN_HEIGHT (480): lines per frame.
- MAX_INFLIGHT, 16: maximum outstanding pixels; must be 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-low.
- start  in  1  pulse; begins a frame when IDLE, ignored otherwise.
- continuous  in  1  sampled at start: 1 = render frames back-to-back.
- stop  in  1  pulse; finish the current frame, then go IDLE.
- pixel_done  in  1  one pulse per pixel completed downstream; returns one credit.
- screen_x  out  32 (fp)  pixel column as an integer in an fp container, 0..SCREEN_WIDTH-1, unshifted.
- screen_y  out  32 (fp)  pixel row, 0..SCREEN_HEIGHT-1.
- coords_valid  out  1  high for exactly one cycle per issued pixel.
- sof  out  1  qualifies coords_valid for pixel (0,0).
- eol  out  1  qualifies coords_valid for x = SCREEN_WIDTH-1.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame fully drains.
- frame_count  out  16  completed frames; wraps at 65535 -> 0.
- credit_err  out  1  sticky; pixel_done received with zero outstanding.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; state IDLE; x = y = 0; inflight = 0; stop_pending = 0; cont_r = 0.
- States:
  - IDLE: start -> SCAN; latch cont_r <= continuous; clear stop_pending.
  - SCAN: issue pixels. After issuing (W-1, H-1) -> DRAIN.
  - DRAIN: wait for inflight == 0, then pulse frame_done and increment frame_count. If cont_r and !stop_pending -> SCAN with x = y = 0; else -> IDLE.
- Issue rule: in SCAN, issue = (inflight < MAX_INFLIGHT), using the registered count. On issue, the next edge registers screen_x/screen_y = current x/y with coords_valid = 1, then advances x. At x == W-1, x wraps to 0 and y increments.
- Latency: start sampled at edge N; state is SCAN after N; first coords_valid is high in the cycle following edge N+1. With no stalls, throughput is 1 pixel/clk.
- Credit counter, per cycle:
  - issue only: +1.
  - pixel_done only: -1.
  - both in the same cycle: unchanged.
  - pixel_done with inflight == 0 and no issue: count stays 0, credit_err set.
- At inflight == MAX_INFLIGHT, coords_valid stays low until a credit returns; the freed slot is usable on the following cycle.
- Coordinate registers hold their last value when coords_valid is low.
- stop: sets stop_pending in any non-IDLE state; no effect in IDLE. It never truncates a frame.
- start while busy: ignored, including in the same cycle as a DRAIN -> IDLE exit.
- frame_done and the frame_count increment happen on the same edge. The back-to-back restart issues the first pixel of the next frame no earlier than one cycle after frame_done.
- credit_err clears only on reset.

Decomposition:
- vector_pkg already supplies fp and FRAC_BITS. Add scan_state_t {IDLE, SCAN, DRAIN} to vector_pkg for reuse by the frame controller.
- Screen constants come from common_defs.svh.
- Natural sub-module: credit_counter (parameter MAX; inputs inc, dec; outputs count, full, underflow_err).

Test Plan:
- W=4, H=3, MAX=16, pixel_done echoed 3 cycles after coords_valid; start with continuous=0 -> 12 consecutive coords_valid, order (0,0),(1,0)..(3,2); sof on the 1st; eol on the 4th, 8th and 12th; one frame_done; frame_count = 1; busy low afterwards.
- W=4, H=3, MAX=2, no pixel_done for 10 cycles -> exactly 2 coords_valid, then stall. One pixel_done -> exactly one more pixel the following cycle.
- MAX=2, pixel_done asserted in the same cycle as an issue while inflight = 1 -> inflight stays 1; 1 pixel/clk sustained.
- continuous=1, stop pulsed mid-way through frame 2 -> frame 2 completes all 12 pixels; frame_count = 2; IDLE; no frame-3 pixels.
- rst low during SCAN at (2,1) -> all outputs 0 immediately (asynchronous). After release, start -> first pixel is (0,0) with sof.
- pixel_done with inflight = 0 -> credit_err = 1 and stays 1; inflight stays 0; subsequent frame renders normally.
